// File: rtl/uart_hex_printer.sv
// uart_hex_printer
// ----------------
// Debug stage between the Wishbone master debug output and uart_tx. A print
// request captures a DATA_WIDTH-bit value and streams it over the UART byte
// handshake as ASCII "0x", uppercase hex digits MSB-first, then optionally
// CR LF. One request may be held pending while a message is in flight; a
// further request while the slot is occupied is dropped and flagged.
//
// Parameters:
//   DATA_WIDTH  width of the printed value, multiple of 4, 4..64
//   NEWLINE     1 = append CR LF after the digits, 0 = no terminator
//
// Optional build macro:
//   HEX_PRINTER_SUPPRESS_LEADING_ZEROS_EN  skip leading zero digits (at least
//                                          one digit is always printed)
//
// Ports:
//   clk_i            system clock
//   rst_i            asynchronous active-high reset
//   value_i          value to print, sampled when printf_i is high
//   printf_i         single-cycle print request strobe
//   tx_data_o        ASCII byte to uart_tx
//   tx_data_valid_o  byte valid
//   tx_data_ready_i  uart_tx can accept a byte
//   busy_o           a message is active or pending
//   done_o           one-cycle pulse after the last byte of a message is taken
//   dropped_o        one-cycle pulse when a request is discarded

module uart_hex_printer #(
  parameter int DATA_WIDTH = 64,
  parameter int NEWLINE    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  printf_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_data_valid_o,
  input  logic                  tx_data_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  dropped_o
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_0, SEND_X, SEND_DIGIT, SEND_CR, SEND_LF, GAP
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, pend_val;
  logic [CW-1:0]         digit_cnt;
  logic                  pend_flag, done_r, dropped_r;

  logic                  transfer, msg_end;
  logic [3:0]            top_nibble;
  logic [DATA_WIDTH-1:0] load_src, load_shift;
  logic [CW-1:0]         load_lz, load_cnt;
  state_t                end_state;

`ifdef HEX_PRINTER_SUPPRESS_LEADING_ZEROS_EN
  // Number of leading zero nibbles, capped so the last digit always prints.
  function automatic logic [CW-1:0] lead_zeros(input logic [DATA_WIDTH-1:0] v);
    logic [CW-1:0] n;
    logic          stop;
    n    = '0;
    stop = 1'b0;
    for (int i = 0; i < NIBBLES - 1; i++) begin
      if (!stop) begin
        if (v[DATA_WIDTH-1-4*i -: 4] == 4'h0) n = n + 1'b1;
        else stop = 1'b1;
      end
    end
    return n;
  endfunction
`endif

  // Load path for the shift register. A new message comes either from the
  // pending slot or straight from value_i (idle start, or a request arriving
  // in the very cycle the previous message ends). With suppression enabled
  // the value is pre-shifted so the first printed digit sits in the top
  // nibble and the counter already excludes the skipped digits.
  always_comb begin
    load_src = pend_flag ? pend_val : value_i;
`ifdef HEX_PRINTER_SUPPRESS_LEADING_ZEROS_EN
    load_lz  = lead_zeros(load_src);
`else
    load_lz  = '0;
`endif
    load_shift = load_src << {load_lz, 2'b00};
    load_cnt   = CW'(NIBBLES - 1) - load_lz;
  end

  assign transfer   = tx_data_valid_o & tx_data_ready_i;
  assign top_nibble = shift_reg[DATA_WIDTH-1 -: 4];

  // The last byte is either the final digit (no terminator) or the LF.
  assign msg_end = transfer &&
                   (((state == SEND_DIGIT) && (digit_cnt == '0) && (NEWLINE == 0)) ||
                    (state == SEND_LF));

  // After a message, go through GAP if anything is waiting to be printed.
  assign end_state = (pend_flag || printf_i) ? GAP : IDLE;

  // Next-state and byte/valid decode.
  always_comb begin
    state_next      = state;
    tx_data_o       = 8'h00;
    tx_data_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (printf_i) state_next = SEND_0;
      end
      SEND_0: begin
        tx_data_o       = 8'h30;
        tx_data_valid_o = 1'b1;
        if (transfer) state_next = SEND_X;
      end
      SEND_X: begin
        tx_data_o       = 8'h78;
        tx_data_valid_o = 1'b1;
        if (transfer) state_next = SEND_DIGIT;
      end
      SEND_DIGIT: begin
        tx_data_o       = (top_nibble < 4'd10) ? (8'h30 + {4'h0, top_nibble})
                                               : (8'h37 + {4'h0, top_nibble});
        tx_data_valid_o = 1'b1;
        if (transfer && (digit_cnt == '0))
          state_next = (NEWLINE != 0) ? SEND_CR : end_state;
      end
      SEND_CR: begin
        tx_data_o       = 8'h0D;
        tx_data_valid_o = 1'b1;
        if (transfer) state_next = SEND_LF;
      end
      SEND_LF: begin
        tx_data_o       = 8'h0A;
        tx_data_valid_o = 1'b1;
        if (transfer) state_next = end_state;
      end
      GAP: begin
        state_next = SEND_0;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, digit datapath and the single pending slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      shift_reg <= '0;
      digit_cnt <= '0;
      pend_val  <= '0;
      pend_flag <= 1'b0;
      done_r    <= 1'b0;
      dropped_r <= 1'b0;
    end else begin
      state     <= state_next;
      done_r    <= msg_end;
      dropped_r <= 1'b0;
      if (state == IDLE) begin
        if (printf_i) begin
          shift_reg <= load_shift;
          digit_cnt <= load_cnt;
        end
      end else begin
        if (msg_end && (pend_flag || printf_i)) begin
          shift_reg <= load_shift;
          digit_cnt <= load_cnt;
        end else if ((state == SEND_DIGIT) && transfer) begin
          shift_reg <= shift_reg << 4;
          digit_cnt <= digit_cnt - 1'b1;
        end
        if (msg_end) pend_flag <= 1'b0;
        // A request in the final cycle with an empty slot is loaded directly
        // above, so it never occupies the pending slot.
        if (printf_i) begin
          if (pend_flag) begin
            dropped_r <= 1'b1;
          end else if (!msg_end) begin
            pend_val  <= value_i;
            pend_flag <= 1'b1;
          end
        end
      end
    end
  end

  assign busy_o    = (state != IDLE) || pend_flag;
  assign done_o    = done_r;
  assign dropped_o = dropped_r;

endmodule

// File: tb/tb_uart_hex_printer.sv
// tb_uart_hex_printer
// -------------------
// Directed bench for uart_hex_printer. A default instance (64-bit, CR LF) and
// a small instance (8-bit, no terminator) share clock and reset. Inputs are
// driven 1 ns after the rising edge, outputs are sampled on the falling edge.
// Expected strings follow HEX_PRINTER_SUPPRESS_LEADING_ZEROS_EN when defined.

module tb_uart_hex_printer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] value;
  logic        printf_s;
  logic        ready;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done, dropped;

  logic [7:0]  s_value;
  logic        s_printf, s_ready;
  logic [7:0]  s_tx_data;
  logic        s_tx_valid, s_busy, s_done, s_dropped;

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  exp_q[$];

  string       str_dead, str_one, str_zero;

  always #5 clk = ~clk;

  uart_hex_printer #(.DATA_WIDTH(64), .NEWLINE(1)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .value_i         (value),
    .printf_i        (printf_s),
    .tx_data_o       (tx_data),
    .tx_data_valid_o (tx_valid),
    .tx_data_ready_i (ready),
    .busy_o          (busy),
    .done_o          (done),
    .dropped_o       (dropped)
  );

  uart_hex_printer #(.DATA_WIDTH(8), .NEWLINE(0)) dut_small (
    .clk_i           (clk),
    .rst_i           (rst),
    .value_i         (s_value),
    .printf_i        (s_printf),
    .tx_data_o       (s_tx_data),
    .tx_data_valid_o (s_tx_valid),
    .tx_data_ready_i (s_ready),
    .busy_o          (s_busy),
    .done_o          (s_done),
    .dropped_o       (s_dropped)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic build_exp(input string digits, input bit nl);
    exp_q.delete();
    for (int i = 0; i < digits.len(); i++) exp_q.push_back(digits[i]);
    if (nl) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Issues a one-cycle request; returns in the first cycle of the message.
  task automatic applyStimulus(input logic [63:0] v);
    @(posedge clk); #1;
    value    = v;
    printf_s = 1'b1;
    @(posedge clk); #1;
    printf_s = 1'b0;
  endtask

  // Expects one byte per cycle with ready held high.
  task automatic expect_message(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s valid%0d", tag, i), {63'd0, tx_valid}, 64'd1);
      checkOutput($sformatf("%s byte%0d", tag, i), {56'd0, tx_data}, {56'd0, exp_q[i]});
      @(posedge clk); #1;
    end
  endtask

  // Expects the same bytes with ready toggling; stalls must hold the byte.
  task automatic expect_message_stall(input string tag);
    int i;
    i     = 0;
    ready = 1'b1;
    for (int c = 0; c < 200 && i < exp_q.size(); c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s valid c%0d", tag, c), {63'd0, tx_valid}, 64'd1);
      checkOutput($sformatf("%s byte c%0d", tag, c), {56'd0, tx_data}, {56'd0, exp_q[i]});
      if (ready) i++;
      @(posedge clk); #1;
      ready = ~ready;
    end
    checkOutput({tag, " count"}, 64'(i), 64'(exp_q.size()));
    ready = 1'b1;
  endtask

  // Cycle after the last transfer with nothing pending.
  task automatic expect_end(input string tag);
    @(negedge clk);
    checkOutput({tag, " done"}, {63'd0, done}, 64'd1);
    checkOutput({tag, " busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, " valid_end"}, {63'd0, tx_valid}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifdef HEX_PRINTER_SUPPRESS_LEADING_ZEROS_EN
    str_dead = "0xDEADBEEF";
    str_one  = "0x1";
    str_zero = "0x0";
`else
    str_dead = "0x00000000DEADBEEF";
    str_one  = "0x0000000000000001";
    str_zero = "0x0000000000000000";
`endif
    rst      = 1'b1;
    value    = '0;
    printf_s = 1'b0;
    ready    = 1'b1;
    s_value  = '0;
    s_printf = 1'b0;
    s_ready  = 1'b1;

    // Reset state
    #1;
    checkOutput("rst tx_data", {56'd0, tx_data}, 64'd0);
    checkOutput("rst valid", {63'd0, tx_valid}, 64'd0);
    checkOutput("rst busy", {63'd0, busy}, 64'd0);
    checkOutput("rst done", {63'd0, done}, 64'd0);
    checkOutput("rst dropped", {63'd0, dropped}, 64'd0);
    checkOutput("rst small valid", {63'd0, s_tx_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", {63'd0, busy}, 64'd0);

    // Basic message, full throughput
    applyStimulus(64'h0000_0000_DEAD_BEEF);
    build_exp(str_dead, 1'b1);
    expect_message("msg1");
    expect_end("msg1");

    // Same message with ready toggling
    applyStimulus(64'h0000_0000_DEAD_BEEF);
    build_exp(str_dead, 1'b1);
    expect_message_stall("stall");
    expect_end("stall");

    // Requests while busy: first pending, next two dropped
    @(posedge clk); #1;
    value    = 64'h0000_0000_DEAD_BEEF;
    printf_s = 1'b1;
    build_exp(str_dead, 1'b1);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk); #1;
      printf_s = (c >= 2 && c <= 4);
      value    = 64'(c - 1);
      @(negedge clk);
      checkOutput($sformatf("pend byte%0d", c), {56'd0, tx_data}, {56'd0, exp_q[c-1]});
      checkOutput($sformatf("pend dropped c%0d", c), {63'd0, dropped},
                  (c == 4 || c == 5) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
    printf_s = 1'b0;
    @(negedge clk);
    checkOutput("gap done", {63'd0, done}, 64'd1);
    checkOutput("gap valid", {63'd0, tx_valid}, 64'd0);
    checkOutput("gap busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    build_exp(str_one, 1'b1);
    expect_message("pend2");
    expect_end("pend2");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("no third c%0d", c), {63'd0, tx_valid}, 64'd0);
    end

    // Reset in the middle of the digits
    applyStimulus(64'h0000_0000_DEAD_BEEF);
    build_exp(str_dead, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("pre-rst byte%0d", i), {56'd0, tx_data}, {56'd0, exp_q[i]});
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("pre-rst byte8", {56'd0, tx_data}, {56'd0, exp_q[8]});
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst valid", {63'd0, tx_valid}, 64'd0);
    checkOutput("midrst busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst tx_data", {56'd0, tx_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
    build_exp("0xFFFFFFFFFFFFFFFF", 1'b1);
    expect_message("postrst");
    expect_end("postrst");

    // Zero value
    applyStimulus(64'h0);
    build_exp(str_zero, 1'b1);
    expect_message("zero");
    expect_end("zero");

    // 8-bit instance without terminator
    @(posedge clk); #1;
    s_value  = 8'hA5;
    s_printf = 1'b1;
    @(posedge clk); #1;
    s_printf = 1'b0;
    build_exp("0xA5", 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("small valid%0d", i), {63'd0, s_tx_valid}, 64'd1);
      checkOutput($sformatf("small byte%0d", i), {56'd0, s_tx_data}, {56'd0, exp_q[i]});
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("small done", {63'd0, s_done}, 64'd1);
    checkOutput("small busy", {63'd0, s_busy}, 64'd0);
    checkOutput("small valid_end", {63'd0, s_tx_valid}, 64'd0);
    checkOutput("small dropped", {63'd0, s_dropped}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
